// File: rtl/cr_lane_status_chk_if.sv
// AUX native-read channel between the CR lane status checker (master)
// and the AUX transaction engine (slave).
`timescale 1ns/1ps
interface cr_lane_status_chk_if;
   logic        rd_req;
   logic [19:0] rd_addr;
   logic [7:0]  rd_len;
   logic        rd_ready;
   logic        rdata_vld;
   logic [7:0]  rdata;
   logic        rd_nack;

   modport master (
      output rd_req,
      output rd_addr,
      output rd_len,
      input  rd_ready,
      input  rdata_vld,
      input  rdata,
      input  rd_nack
   );

   modport slave (
      input  rd_req,
      input  rd_addr,
      input  rd_len,
      output rd_ready,
      output rdata_vld,
      output rdata,
      output rd_nack
   );
endinterface

// File: rtl/cr_lane_status_chk.sv
// CR lane status poller: on each poll reads DPCD 0x202..0x207 over AUX,
// checks CR_DONE on the active lanes and either reports CR complete or
// hands the sink's packed adjust requests to the CR error checker.
`timescale 1ns/1ps
module cr_lane_status_chk #(
   parameter int unsigned TIMEOUT_CYC = 1000,
   parameter logic [19:0] DPCD_BASE   = 20'h00202,
   parameter logic [7:0]  RD_LEN      = 8'd6
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cr_status_req_i,
   input  logic [1:0]                   link_lc_i,
   cr_lane_status_chk_if.master         aux,
   output logic                         busy_o,
   output logic                         cr_done_o,
   output logic                         cr_chk_start_o,
   output logic [7:0]                   adj_vtg_o,
   output logic [7:0]                   adj_pre_o,
   output logic                         status_err_o
);

   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_COLLECT = 2'd2,
      ST_EVAL    = 2'd3
   } state_t;

   // Active-lane mask from the latched lane count; 2'b10 is treated as 4 lanes.
   function automatic logic [3:0] lane_mask(input logic [1:0] lc);
      logic [3:0] m;
      case (lc)
         2'b00:   m = 4'b0001;
         2'b01:   m = 4'b0011;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Widen a per-lane mask to the 2-bit-per-lane adjust field layout.
   function automatic logic [7:0] field_mask(input logic [3:0] lm);
      return {{2{lm[3]}}, {2{lm[2]}}, {2{lm[1]}}, {2{lm[0]}}};
   endfunction

   state_t          state_q, state_d;
   logic [1:0]      lc_q, lc_d;
   logic [2:0]      idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [5:0][7:0] bytes_q, bytes_d;
   logic            rd_req_q, rd_req_d;
   logic [19:0]     rd_addr_q, rd_addr_d;
   logic [7:0]      rd_len_q, rd_len_d;
   logic            busy_q, busy_d;
   logic            cr_done_q, cr_done_d;
   logic            cr_chk_start_q, cr_chk_start_d;
   logic            status_err_q, status_err_d;
   logic [7:0]      adj_vtg_q, adj_vtg_d;
   logic [7:0]      adj_pre_q, adj_pre_d;

   logic [3:0]      lane_en_s;
   logic [3:0]      done_bits_s;
   logic            all_done_s;
   logic [7:0]      vtg_s;
   logic [7:0]      pre_s;

   // Decode CR_DONE and adjust requests of the captured status bytes.
   always_comb begin
      lane_en_s   = lane_mask(lc_q);
      done_bits_s = {bytes_q[1][4], bytes_q[1][0], bytes_q[0][4], bytes_q[0][0]};
      all_done_s  = &(done_bits_s | ~lane_en_s);
      vtg_s = {bytes_q[5][5:4], bytes_q[5][1:0], bytes_q[4][5:4], bytes_q[4][1:0]}
              & field_mask(lane_en_s);
      pre_s = {bytes_q[5][7:6], bytes_q[5][3:2], bytes_q[4][7:6], bytes_q[4][3:2]}
              & field_mask(lane_en_s);
   end

   // Poll sequencing, byte capture, timeout/NACK abort and result pulses.
   always_comb begin
      state_d        = state_q;
      lc_d           = lc_q;
      idx_d          = idx_q;
      cnt_d          = cnt_q;
      bytes_d        = bytes_q;
      adj_vtg_d      = adj_vtg_q;
      adj_pre_d      = adj_pre_q;
      cr_done_d      = 1'b0;
      cr_chk_start_d = 1'b0;
      status_err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cr_status_req_i) begin
               state_d = ST_REQ;
               lc_d    = link_lc_i;
               idx_d   = 3'd0;
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (aux.rd_nack) begin
               state_d      = ST_IDLE;
               status_err_d = 1'b1;
               cnt_d        = '0;
            end else if (aux.rd_ready) begin
               state_d = ST_COLLECT;
               idx_d   = 3'd0;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d      = ST_IDLE;
               status_err_d = 1'b1;
               cnt_d        = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_COLLECT: begin
            if (aux.rd_nack) begin
               state_d      = ST_IDLE;
               status_err_d = 1'b1;
               cnt_d        = '0;
            end else if (aux.rdata_vld) begin
               for (int i = 0; i < 6; i++) begin
                  if (idx_q == 3'(i)) begin
                     bytes_d[i] = aux.rdata;
                  end else begin
                     bytes_d[i] = bytes_q[i];
                  end
               end
               cnt_d = '0;
               if (idx_q == 3'd5) begin
                  state_d = ST_EVAL;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d      = ST_IDLE;
               status_err_d = 1'b1;
               cnt_d        = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_EVAL: begin
            state_d = ST_IDLE;
            if (all_done_s) begin
               cr_done_d = 1'b1;
            end else begin
               cr_chk_start_d = 1'b1;
               adj_vtg_d      = vtg_s;
               adj_pre_d      = pre_s;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d    = (state_d != ST_IDLE);
      rd_req_d  = (state_d == ST_REQ);
      rd_addr_d = rd_req_d ? DPCD_BASE : 20'h00000;
      rd_len_d  = rd_req_d ? RD_LEN : 8'h00;
   end

   // State and output registers; reset returns to IDLE with every output low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         lc_q           <= 2'b00;
         idx_q          <= 3'd0;
         cnt_q          <= '0;
         bytes_q        <= '0;
         rd_req_q       <= 1'b0;
         rd_addr_q      <= 20'h00000;
         rd_len_q       <= 8'h00;
         busy_q         <= 1'b0;
         cr_done_q      <= 1'b0;
         cr_chk_start_q <= 1'b0;
         status_err_q   <= 1'b0;
         adj_vtg_q      <= 8'h00;
         adj_pre_q      <= 8'h00;
      end else begin
         state_q        <= state_d;
         lc_q           <= lc_d;
         idx_q          <= idx_d;
         cnt_q          <= cnt_d;
         bytes_q        <= bytes_d;
         rd_req_q       <= rd_req_d;
         rd_addr_q      <= rd_addr_d;
         rd_len_q       <= rd_len_d;
         busy_q         <= busy_d;
         cr_done_q      <= cr_done_d;
         cr_chk_start_q <= cr_chk_start_d;
         status_err_q   <= status_err_d;
         adj_vtg_q      <= adj_vtg_d;
         adj_pre_q      <= adj_pre_d;
      end
   end

   assign aux.rd_req     = rd_req_q;
   assign aux.rd_addr    = rd_addr_q;
   assign aux.rd_len     = rd_len_q;
   assign busy_o         = busy_q;
   assign cr_done_o      = cr_done_q;
   assign cr_chk_start_o = cr_chk_start_q;
   assign status_err_o   = status_err_q;
   assign adj_vtg_o      = adj_vtg_q;
   assign adj_pre_o      = adj_pre_q;

endmodule
